// File: rtl/ceasar_pkg.sv
// ==========================================================================
// ceasar_pkg: shared widths and character constants for the Caesar decoder
// Rev 1.0
// ==========================================================================
`default_nettype none

package ceasar_pkg;
    localparam int         D_WIDTH_DEF   = 8;
    localparam int         KEY_WIDTH_DEF = 16;
    localparam int         ALPHA_LEN     = 26;
    localparam logic [7:0] CHAR_UP_A     = 8'h41;
    localparam logic [7:0] CHAR_UP_Z     = 8'h5A;
    localparam logic [7:0] CHAR_LO_A     = 8'h61;
    localparam logic [7:0] CHAR_LO_Z     = 8'h7A;
endpackage

`default_nettype wire

// File: rtl/ceasar_shift.sv
// ==========================================================================
// ceasar_shift: combinational back-shift of one character by the key. Rev 1.0
// Macro CEASAR_ALPHA_WRAP_EN: rotate letters within A-Z / a-z, pass others.
// ==========================================================================
`default_nettype none

module ceasar_shift
    import ceasar_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic [D_WIDTH-1:0] char_i,
    input  logic [D_WIDTH-1:0] key_i,
    output logic [D_WIDTH-1:0] char_o
);

`ifdef CEASAR_ALPHA_WRAP_EN
    logic [D_WIDTH-1:0] w_k;
    logic [D_WIDTH-1:0] w_base;
    logic [D_WIDTH-1:0] w_off;
    logic [D_WIDTH-1:0] w_rot;
    logic               w_is_up;
    logic               w_is_lo;

    assign w_k     = key_i % D_WIDTH'(ALPHA_LEN);
    assign w_is_up = (char_i >= D_WIDTH'(CHAR_UP_A)) && (char_i <= D_WIDTH'(CHAR_UP_Z));
    assign w_is_lo = (char_i >= D_WIDTH'(CHAR_LO_A)) && (char_i <= D_WIDTH'(CHAR_LO_Z));
    assign w_base  = w_is_up ? D_WIDTH'(CHAR_UP_A) : D_WIDTH'(CHAR_LO_A);
    assign w_off   = char_i - w_base;
    // Offset stays in 0..25, so one conditional add of ALPHA_LEN handles the wrap.
    assign w_rot   = (w_off >= w_k) ? (w_off - w_k) : (w_off + D_WIDTH'(ALPHA_LEN) - w_k);
    assign char_o  = (w_is_up || w_is_lo) ? (w_base + w_rot) : char_i;
`else
    assign char_o = char_i - key_i;
`endif

endmodule

`default_nettype wire

// File: rtl/ceasar_decryption.sv
// ==========================================================================
// ceasar_decryption: one-cycle registered Caesar decoder. Rev 1.0
// Macro CEASAR_ALPHA_WRAP_EN selects alphabetic wrap in ceasar_shift.
// ==========================================================================
`default_nettype none

module ceasar_decryption
    import ceasar_pkg::*;
#(
    parameter int D_WIDTH   = D_WIDTH_DEF,
    parameter int KEY_WIDTH = KEY_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
);

    logic [D_WIDTH-1:0] w_shifted;
    logic [D_WIDTH-1:0] data_d;
    logic [D_WIDTH-1:0] data_q;
    logic               valid_d;
    logic               valid_q;

    ceasar_shift #(
        .D_WIDTH (D_WIDTH)
    ) u_shift (
        .char_i (data_i),
        .key_i  (key[D_WIDTH-1:0]),
        .char_o (w_shifted)
    );

    // Key bits above the character width have no effect on the result.
    generate
        if (KEY_WIDTH > D_WIDTH) begin : g_key_hi
            logic w_unused_key_hi;
            assign w_unused_key_hi = ^key[KEY_WIDTH-1:D_WIDTH];
        end
    endgenerate

    assign data_d  = valid_i ? w_shifted : '0;
    assign valid_d = valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ceasar_decryption.sv
// ==========================================================================
// tb_ceasar_decryption: scoreboard bench for ceasar_decryption. Rev 1.0
// Build with CEASAR_ALPHA_WRAP_EN defined to check the alphabetic mode.
// ==========================================================================
`default_nettype none

module tb_ceasar_decryption;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [15:0] key;
    logic [7:0]  data_o;
    logic        valid_o;

    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];

    ceasar_decryption #(
        .D_WIDTH   (8),
        .KEY_WIDTH (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .key     (key),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model(input logic [7:0] d, input logic [15:0] k);
        int kk;
        int di;
        kk = int'(k[7:0]);
        di = int'(d);
`ifdef CEASAR_ALPHA_WRAP_EN
        if (di >= 65 && di <= 90)  return 8'(65 + (di - 65 - (kk % 26) + 26) % 26);
        if (di >= 97 && di <= 122) return 8'(97 + (di - 97 - (kk % 26) + 26) % 26);
        return d;
`else
        return 8'((di - kk + 256) % 256);
`endif
    endfunction

    // Drive one cycle of input, push the expectation, check it one edge later.
    task automatic step(input logic v, input logic [7:0] d, input logic [15:0] k, input string nm);
        exp_t e;
        exp_t got;
        valid_i = v;
        data_i  = d;
        key     = k;
        e.v = v;
        e.d = v ? model(d, k) : 8'h00;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        n_cmp++;
        if (valid_o !== got.v) begin
            n_err++;
            $display("FAIL %s valid_o: got %b expected %b", nm, valid_o, got.v);
        end
        n_cmp++;
        if (data_o !== got.d) begin
            n_err++;
            $display("FAIL %s data_o: got %h expected %h", nm, data_o, got.d);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h44;
        key     = 16'h0003;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (valid_o !== 1'b0 || data_o !== 8'h00) begin
                n_err++;
                $display("FAIL reset_held[%0d]: got v=%b d=%h expected v=0 d=00", i, valid_o, data_o);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        step(1'b1, 8'h44, 16'h0003, "stream0");
        step(1'b1, 8'h51, 16'h0003, "stream1");
        step(1'b1, 8'h44, 16'h0003, "stream2");
        step(1'b1, 8'h41, 16'h0003, "stream3");
        // Direct constant check for the last character of the stream.
        n_cmp++;
`ifdef CEASAR_ALPHA_WRAP_EN
        if (data_o !== 8'h58) begin
            n_err++;
            $display("FAIL stream3_const: got %h expected 58", data_o);
        end
`else
        if (data_o !== 8'h3E) begin
            n_err++;
            $display("FAIL stream3_const: got %h expected 3e", data_o);
        end
`endif
    endtask

    task automatic test_idle();
        step(1'b0, 8'h00, 16'h0003, "idle0");
        step(1'b0, 8'h5A, 16'h0007, "idle1");
    endtask

    task automatic test_wide_key();
        step(1'b1, 8'h44, 16'h0103, "wide_key");
        step(1'b1, 8'h61, 16'hFF1B, "wide_key_lo");
    endtask

    task automatic test_underflow();
        step(1'b1, 8'h01, 16'h0003, "underflow");
        step(1'b1, 8'h00, 16'h00FF, "underflow_ff");
        step(1'b1, 8'h7A, 16'h0019, "lower_z");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  d;
        logic [15:0] k;
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom_range(0, 255));
            k = 16'($urandom);
            step(1'b1, d, k, $sformatf("b2b%0d", i));
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 8'h55, 16'h0002, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (valid_o !== 1'b0 || data_o !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset: got v=%b d=%h expected v=0 d=00", valid_o, data_o);
        end
        valid_i = 1'b1;
        data_i  = 8'h66;
        key     = 16'h0001;
        @(posedge clk);
        #1;
        n_cmp++;
        if (valid_o !== 1'b0 || data_o !== 8'h00) begin
            n_err++;
            $display("FAIL in_flight_discard: got v=%b d=%h expected v=0 d=00", valid_o, data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h62, 16'h0001, "first_after_reset");
        step(1'b0, 8'h00, 16'h0000, "idle_after_reset");
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        key     = 16'h0000;
        test_reset();
        test_stream();
        test_idle();
        test_wide_key();
        test_underflow();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ceasar_decryption.md
CEASAR_DECRYPTION -- requirements
Module: ceasar_decryption

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, data byte width.
REQ-002 SHALL have parameter KEY_WIDTH, default 16, key width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_i  input  D_WIDTH  ciphertext character.
REQ-006 SHALL have port valid_i  input  1  data_i qualifier, sampled each rising edge.
REQ-007 SHALL have port key  input  KEY_WIDTH  shift amount, sampled on the same edge as data_i.
REQ-008 SHALL have port data_o  output  D_WIDTH  plaintext character, registered.
REQ-009 SHALL have port valid_o  output  1  data_o qualifier, registered.

Function
REQ-010 SHALL, on a rising edge with valid_i=1, register data_o = (data_i - key) modulo 2^D_WIDTH and set valid_o=1; latency is exactly 1 cycle.
REQ-011 SHALL use only key[D_WIDTH-1:0] in the subtraction; upper key bits are ignored (key mod 256).
REQ-012 SHALL, on a rising edge with valid_i=0, register valid_o=0 and data_o=0.
REQ-013 SHALL accept one character per cycle with no backpressure; back-to-back valid_i produces back-to-back valid_o.
REQ-014 SHALL treat key changes between characters as immediate; each character uses the key present on its own sampling edge.
REQ-015 SHALL wrap on underflow: data_i=0x01, key=3 -> data_o=0xFE.
REQ-016 SHALL contain no state machine; the only state is the data_o and valid_o registers.

Reset
REQ-017 SHALL force data_o=0 and valid_o=0 immediately when rst_n goes low, independent of clk.
REQ-018 SHALL hold data_o=0 and valid_o=0 for as long as rst_n=0, ignoring valid_i, data_i and key.
REQ-019 SHALL process the first valid character on the first rising edge after rst_n returns high.
REQ-020 SHALL discard any character in flight when reset is asserted mid-stream; no output is produced for it.

Configuration
REQ-021 SHALL support macro CEASAR_ALPHA_WRAP_EN.
REQ-022 With CEASAR_ALPHA_WRAP_EN defined, characters 'A'-'Z' (0x41-0x5A) SHALL be shifted back by key mod 26 and wrap within 'A'-'Z'; 'a'-'z' likewise within 'a'-'z'; all other bytes SHALL pass through unchanged.
REQ-023 Without CEASAR_ALPHA_WRAP_EN, the plain modulo-256 subtraction of REQ-010 SHALL apply to every byte.
REQ-024 SHALL have identical latency, handshake and reset behaviour in both configurations.

Structure
REQ-025 SHALL place D_WIDTH and KEY_WIDTH defaults, ALPHA_LEN=26, and the 'A', 'Z', 'a', 'z' character constants in shared package ceasar_pkg.
REQ-026 SHALL implement the shift arithmetic in one combinational sub-module ceasar_shift (inputs: character, key; output: shifted character); the top module holds only the output registers.

Verification
REQ-027 Reset held: rst_n=0, valid_i=1, data_i=0x44, key=3 for 4 cycles -> data_o=0x00, valid_o=0 throughout.
REQ-028 Stream: after reset release, key=3, valid_i=1, data_i 0x44, 0x51, 0x44, 0x41 on consecutive edges -> one cycle later data_o 0x41, 0x4E, 0x41, then 0x3E (plain) or 0x58 (CEASAR_ALPHA_WRAP_EN), valid_o=1 for 4 cycles.
REQ-029 Idle: valid_i=0, data_i=0x00 -> next cycle valid_o=0, data_o=0x00.
REQ-030 Wide key: key=0x0103, data_i=0x44, valid_i=1 -> data_o=0x41 (plain mode; upper byte ignored).
REQ-031 Async reset: pull rst_n low between clock edges while valid_o=1 -> data_o=0x00, valid_o=0 before the next rising edge.
REQ-032 Underflow: key=3, data_i=0x01, valid_i=1, plain mode -> data_o=0xFE, valid_o=1.
